// File: rtl/neighbor_admit_pkg.sv
// rtl/neighbor_admit_pkg.sv - packet type codes, admitter FSM states and node defaults
package neighbor_admit_pkg;

   localparam logic [2:0]  PKT_MEMREQ         = 3'd2;
   localparam logic [2:0]  PKT_DATA           = 3'd3;
   localparam logic [2:0]  PKT_SOS            = 3'd4;
   localparam logic [15:0] MY_NODE_ID_DEFAULT = 16'h000C;
   localparam int          IDX_W              = 5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_WRITE,
      S_HOLD
   } state_t;

   // Only these overheard packet kinds carry neighbour information worth recording.
   function automatic logic type_admissible(input logic [2:0] t);
      return (t == PKT_MEMREQ) || (t == PKT_DATA) || (t == PKT_SOS);
   endfunction

endpackage

// File: rtl/neighbor_admit.sv
// rtl/neighbor_admit.sv - filters overheard packets and inserts/updates senders in the neighbour table
module neighbor_admit
   import neighbor_admit_pkg::*;
#(
   parameter int                    WORD_WIDTH    = 16,
   parameter int                    MAX_NEIGHBORS = 32,
   parameter logic [WORD_WIDTH-1:0] MY_NODE_ID    = WORD_WIDTH'(MY_NODE_ID_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  HB_reset,
   input  logic                  pkt_valid,
   output logic                  pkt_ready,
   input  logic [2:0]            pkt_type,
   input  logic [WORD_WIDTH-1:0] pkt_srcID,
   input  logic [WORD_WIDTH-1:0] pkt_hops,
   input  logic [WORD_WIDTH-1:0] pkt_qvalue,
   input  logic [WORD_WIDTH-1:0] pkt_energy,
   input  logic [WORD_WIDTH-1:0] pkt_chosenCH,
   input  logic [WORD_WIDTH-1:0] pkt_CHhops,
   input  logic [WORD_WIDTH-1:0] my_chosenCH,
   input  logic [WORD_WIDTH-1:0] nt_rdID,
   output logic [IDX_W-1:0]      nt_index,
   output logic                  nt_wr_en,
   output logic [WORD_WIDTH-1:0] nt_nodeID,
   output logic [WORD_WIDTH-1:0] nt_hops,
   output logic [WORD_WIDTH-1:0] nt_qvalue,
   output logic [WORD_WIDTH-1:0] nt_energy,
   output logic [WORD_WIDTH-1:0] nt_CHhops,
   output logic [5:0]            neighbor_total,
   output logic                  table_full
);

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      scan_q, scan_d;
   logic [IDX_W-1:0]      slot_q, slot_d;
   logic [5:0]            total_q, total_d;
   logic [WORD_WIDTH-1:0] src_q, hops_q, qvalue_q, energy_q, chhops_q;

   logic handshake;
   logic admit;
   logic last_scan;
   logic full;

   assign pkt_ready = (state_q == S_IDLE) && !HB_reset;
   assign handshake = pkt_valid && pkt_ready;
   assign admit     = type_admissible(pkt_type) && (pkt_chosenCH == my_chosenCH) &&
                      (pkt_srcID != MY_NODE_ID);
   assign last_scan = ({1'b0, scan_q} == (total_q - 6'd1));
   assign full      = (total_q == 6'(MAX_NEIGHBORS));

   // Next-state: heartbeat reset wins over everything; scan walks valid slots looking for the sender.
   always_comb begin
      state_d = state_q;
      scan_d  = scan_q;
      slot_d  = slot_q;
      total_d = total_q;
      if (HB_reset) begin
         state_d = S_IDLE;
         scan_d  = '0;
         slot_d  = '0;
         total_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (handshake && admit) begin
                  scan_d = '0;
                  if (total_q != 6'd0) begin
                     state_d = S_SCAN;
                  end else begin
                     slot_d  = '0;
                     total_d = 6'd1;
                     state_d = S_WRITE;
                  end
               end
            end
            S_SCAN: begin
               if (nt_rdID == src_q) begin
                  slot_d  = scan_q;
                  state_d = S_WRITE;
               end else if (last_scan) begin
                  if (full) begin
                     state_d = S_IDLE;
                  end else begin
                     slot_d  = total_q[IDX_W-1:0];
                     total_d = total_q + 6'd1;
                     state_d = S_WRITE;
                  end
               end else begin
                  scan_d = scan_q + 1'b1;
               end
            end
            S_WRITE: state_d = S_HOLD;
            S_HOLD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         scan_q  <= '0;
         slot_q  <= '0;
         total_q <= '0;
      end else begin
         state_q <= state_d;
         scan_q  <= scan_d;
         slot_q  <= slot_d;
         total_q <= total_d;
      end
   end

   // Capture the sender fields on every accepted packet; they stay put until the next accept.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         src_q    <= '0;
         hops_q   <= '0;
         qvalue_q <= '0;
         energy_q <= '0;
         chhops_q <= '0;
      end else if (handshake) begin
         src_q    <= pkt_srcID;
         hops_q   <= pkt_hops;
         qvalue_q <= pkt_qvalue;
         energy_q <= pkt_energy;
         chhops_q <= pkt_CHhops;
      end
   end

   // Table address: scan pointer while searching, chosen slot while writing and holding.
   always_comb begin
      nt_index = '0;
      case (state_q)
         S_SCAN:          nt_index = scan_q;
         S_WRITE, S_HOLD: nt_index = slot_q;
         default:         nt_index = '0;
      endcase
   end

   assign nt_wr_en       = (state_q == S_WRITE);
   assign nt_nodeID      = src_q;
   assign nt_hops        = hops_q;
   assign nt_qvalue      = qvalue_q;
   assign nt_energy      = energy_q;
   assign nt_CHhops      = chhops_q;
   assign neighbor_total = total_q;
   assign table_full     = full;

endmodule

// File: tb/tb_neighbor_admit.sv
// tb/tb_neighbor_admit.sv - scoreboard bench for neighbor_admit with a behavioural table model
module tb_neighbor_admit;

   localparam logic [15:0] MY_ID = 16'h000C;
   localparam logic [15:0] MY_CH = 16'h0003;

   logic        clk = 1'b0;
   logic        nrst, HB_reset, pkt_valid, pkt_ready;
   logic [2:0]  pkt_type;
   logic [15:0] pkt_srcID, pkt_hops, pkt_qvalue, pkt_energy, pkt_chosenCH, pkt_CHhops;
   logic [15:0] my_chosenCH, nt_rdID;
   logic [4:0]  nt_index;
   logic        nt_wr_en;
   logic [15:0] nt_nodeID, nt_hops, nt_qvalue, nt_energy, nt_CHhops;
   logic [5:0]  neighbor_total;
   logic        table_full;

   neighbor_admit dut (
      .clk(clk), .nrst(nrst), .HB_reset(HB_reset),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_type(pkt_type),
      .pkt_srcID(pkt_srcID), .pkt_hops(pkt_hops), .pkt_qvalue(pkt_qvalue),
      .pkt_energy(pkt_energy), .pkt_chosenCH(pkt_chosenCH), .pkt_CHhops(pkt_CHhops),
      .my_chosenCH(my_chosenCH), .nt_rdID(nt_rdID), .nt_index(nt_index),
      .nt_wr_en(nt_wr_en), .nt_nodeID(nt_nodeID), .nt_hops(nt_hops),
      .nt_qvalue(nt_qvalue), .nt_energy(nt_energy), .nt_CHhops(nt_CHhops),
      .neighbor_total(neighbor_total), .table_full(table_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      int slot; int node; int hops; int qv; int en; int chh; int total; int lat; int acc;
   } exp_t;

   exp_t sb[$];
   int   ids[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_acc = 0;

   logic [15:0] tbl [32];
   logic        commit_q;

   always @(posedge clk) cyc <= cyc + 1;

   initial foreach (tbl[i]) tbl[i] = 16'h0;

   assign nt_rdID = tbl[nt_index];

   always @(posedge clk or negedge nrst) begin
      if (!nrst) commit_q <= 1'b0;
      else begin
         commit_q <= nt_wr_en;
         if (commit_q) tbl[nt_index] <= nt_nodeID;
      end
   end

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   // Offers one packet; the reference model decides admission and the expected table effect.
   task automatic send(input logic [2:0] t, input logic [15:0] src, input logic [15:0] ch,
                       input int energy, output bit adm, output bit dropped);
      int   n;
      int   k;
      exp_t e;
      adm = 1'b0;
      dropped = 1'b0;
      @(negedge clk);
      n = 0;
      while (!pkt_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!pkt_ready) begin
         chk("ready_timeout", 0, 1);
         return;
      end
      pkt_type     = t;
      pkt_srcID    = src;
      pkt_chosenCH = ch;
      pkt_hops     = 16'($urandom_range(0, 65535));
      pkt_qvalue   = 16'($urandom_range(0, 65535));
      pkt_CHhops   = 16'($urandom_range(0, 65535));
      pkt_energy   = (energy >= 0) ? 16'(energy) : 16'($urandom_range(0, 65535));
      pkt_valid    = 1'b1;
      last_acc     = cyc;
      adm = (t == 3'd2 || t == 3'd3 || t == 3'd4) && (ch == MY_CH) && (src != MY_ID);
      if (adm) begin
         k = -1;
         foreach (ids[i]) if (k < 0 && ids[i] == int'(src)) k = i;
         if (k >= 0) begin
            e.slot = k; e.lat = k + 2;
         end else if (ids.size() < 32) begin
            e.slot = ids.size(); e.lat = ids.size() + 1; ids.push_back(int'(src));
         end else dropped = 1'b1;
         if (!dropped) begin
            e.node = src; e.hops = pkt_hops; e.qv = pkt_qvalue; e.en = pkt_energy;
            e.chh = pkt_CHhops; e.total = ids.size(); e.acc = cyc;
            sb.push_back(e);
         end
      end
      @(negedge clk);
      pkt_valid = 1'b0;
   endtask

   task automatic hb_pulse();
      @(negedge clk);
      HB_reset = 1'b1;
      sb.delete();
      ids.delete();
      @(negedge clk);
      HB_reset = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || !pkt_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", int'(sb.size() == 0 && pkt_ready), 1);
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (nrst && nt_wr_en) begin
            if (sb.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               e = sb.pop_front();
               chk("wr_slot", int'(nt_index), e.slot);
               chk("wr_latency", cyc - e.acc, e.lat);
               chk("wr_total", int'(neighbor_total), e.total);
               chk("wr_nodeID", int'(nt_nodeID), e.node);
               chk("wr_hops", int'(nt_hops), e.hops);
               chk("wr_qvalue", int'(nt_qvalue), e.qv);
               chk("wr_energy", int'(nt_energy), e.en);
               chk("wr_CHhops", int'(nt_CHhops), e.chh);
               @(negedge clk);
               if (nrst) begin
                  chk("hold_wr_en", int'(nt_wr_en), 0);
                  chk("hold_index", int'(nt_index), e.slot);
                  chk("hold_nodeID", int'(nt_nodeID), e.node);
               end
            end
         end
      end
   end

   initial begin
      bit adm, drp;
      int n;
      int tot;
      logic [2:0] t;
      logic [15:0] ch;
      nrst = 1'b0; HB_reset = 1'b0; pkt_valid = 1'b0; pkt_type = 3'd0;
      pkt_srcID = '0; pkt_hops = '0; pkt_qvalue = '0; pkt_energy = '0;
      pkt_chosenCH = '0; pkt_CHhops = '0; my_chosenCH = MY_CH;
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      #1;
      chk("rst_ready", int'(pkt_ready), 1);
      chk("rst_total", int'(neighbor_total), 0);
      chk("rst_wr_en", int'(nt_wr_en), 0);
      chk("rst_index", int'(nt_index), 0);
      chk("rst_nodeID", int'(nt_nodeID), 0);
      chk("rst_full", int'(table_full), 0);

      // Empty table, then a new neighbour, then an in-place update.
      send(3'd2, 16'h0005, MY_CH, -1, adm, drp);
      send(3'd3, 16'h0007, MY_CH, -1, adm, drp);
      send(3'd3, 16'h0007, MY_CH, 16'h1234, adm, drp);
      drain();
      chk("update_total", int'(neighbor_total), 2);

      // Three rejection causes.
      send(3'd2, MY_ID, MY_CH, -1, adm, drp);
      chk("rej_self_ready", int'(pkt_ready), 1);
      chk("rej_self_total", int'(neighbor_total), 2);
      send(3'd2, 16'h0009, MY_CH ^ 16'h0001, -1, adm, drp);
      chk("rej_ch_ready", int'(pkt_ready), 1);
      chk("rej_ch_total", int'(neighbor_total), 2);
      send(3'd1, 16'h0009, MY_CH, -1, adm, drp);
      chk("rej_type_ready", int'(pkt_ready), 1);
      chk("rej_type_total", int'(neighbor_total), 2);

      // Random traffic over a small ID pool.
      for (int i = 0; i < 80; i++) begin
         t  = ($urandom_range(0, 3) != 0) ? 3'(2 + $urandom_range(0, 2)) : 3'($urandom_range(0, 7));
         ch = ($urandom_range(0, 9) == 0) ? (MY_CH ^ 16'h0010) : MY_CH;
         send(t, 16'($urandom_range(1, 16)), ch, -1, adm, drp);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();
      tot = ids.size();
      chk("rand_total", int'(neighbor_total), tot);

      // Fill to capacity, drop a newcomer, then update an existing entry.
      hb_pulse();
      chk("hb_clear_total", int'(neighbor_total), 0);
      for (int i = 0; i < 32; i++) send(3'd3, 16'(16'h0100 + i), MY_CH, -1, adm, drp);
      drain();
      chk("fill_total", int'(neighbor_total), 32);
      chk("fill_full", int'(table_full), 1);
      send(3'd2, 16'h0040, MY_CH, -1, adm, drp);
      n = 0;
      while (!pkt_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drop_ready_latency", cyc - last_acc, 33);
      chk("drop_total", int'(neighbor_total), 32);
      send(3'd4, 16'h0114, MY_CH, -1, adm, drp);
      drain();
      chk("full_update_total", int'(neighbor_total), 32);

      // Heartbeat reset in the middle of a scan over 10 entries.
      hb_pulse();
      for (int i = 0; i < 10; i++) send(3'd2, 16'(16'h0200 + i), MY_CH, -1, adm, drp);
      drain();
      send(3'd2, 16'h0300, MY_CH, -1, adm, drp);
      HB_reset = 1'b1;
      sb.delete();
      ids.delete();
      @(negedge clk);
      chk("hb_scan_total", int'(neighbor_total), 0);
      chk("hb_scan_wr_en", int'(nt_wr_en), 0);
      chk("hb_scan_index", int'(nt_index), 0);
      HB_reset = 1'b0;
      #1;
      chk("hb_scan_ready", int'(pkt_ready), 1);
      repeat (12) @(negedge clk);
      send(3'd2, 16'h0301, MY_CH, -1, adm, drp);
      drain();

      // Power-on reset while the write strobe is up.
      send(3'd3, 16'h0302, MY_CH, -1, adm, drp);
      n = 0;
      while (!nt_wr_en && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("nrst_saw_write", int'(nt_wr_en), 1);
      #2;
      nrst = 1'b0;
      #1;
      chk("nrst_wr_en", int'(nt_wr_en), 0);
      chk("nrst_total", int'(neighbor_total), 0);
      chk("nrst_index", int'(nt_index), 0);
      chk("nrst_nodeID", int'(nt_nodeID), 0);
      chk("nrst_energy", int'(nt_energy), 0);
      sb.delete();
      ids.delete();
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b1;
      repeat (6) @(negedge clk);
      send(3'd2, 16'h0303, MY_CH, -1, adm, drp);
      drain();

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/neighbor_admit.md
NEIGHBOR_ADMIT -- requirements
Module: neighbor_admit

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16, field width of every packet word.
REQ-002 SHALL have parameter MAX_NEIGHBORS, default 32, table depth; index width is 5.
REQ-003 SHALL have parameter MY_NODE_ID, default 16'h000C, own node address.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- HB_reset  in  1  heartbeat reset, shared with the neighbour table.
- pkt_valid  in  1  parsed overheard packet present.
- pkt_ready  out  1  admitter can accept a packet.
- pkt_type  in  3  packet type code.
- pkt_srcID, pkt_hops, pkt_qvalue, pkt_energy, pkt_chosenCH, pkt_CHhops  in  WORD_WIDTH each  sender fields.
- my_chosenCH  in  WORD_WIDTH  own cluster head.
- nt_rdID  in  WORD_WIDTH  table nodeID readback at nt_index (combinational).
- nt_index  out  5  table slot (neighborCount).
- nt_wr_en  out  1  table write request.
- nt_nodeID, nt_hops, nt_qvalue, nt_energy, nt_CHhops  out  WORD_WIDTH each  table write data.
- neighbor_total  out  6  valid entries, 0..32.
- table_full  out  1  neighbor_total == MAX_NEIGHBORS.

Function
REQ-005 SHALL run an FSM with states S_IDLE, S_SCAN, S_WRITE, S_HOLD.
REQ-006 pkt_ready SHALL be 1 only in S_IDLE with HB_reset==0; handshake = pkt_valid & pkt_ready in one cycle.
REQ-007 On handshake, SHALL latch all pkt_* fields.
REQ-008 A packet SHALL be admitted only if all hold:
- pkt_type ∈ {PKT_MEMREQ, PKT_DATA, PKT_SOS};
- pkt_chosenCH == my_chosenCH;
- pkt_srcID != MY_NODE_ID.
REQ-009 A rejected packet SHALL leave the FSM in S_IDLE, with no table activity.
REQ-010 An admitted packet SHALL go to S_SCAN if neighbor_total > 0, else to S_WRITE with slot 0.
REQ-011 S_SCAN SHALL drive nt_index = scan index, starting at 0 and advancing by 1 per cycle, and compare nt_rdID with the latched srcID in the same cycle.
REQ-012 On a match at index k, S_SCAN SHALL go to S_WRITE with slot k (update in place); neighbor_total is unchanged.
REQ-013 On no match at index neighbor_total-1:
- if not full, SHALL go to S_WRITE with slot neighbor_total and increment neighbor_total on entering S_WRITE;
- if full, SHALL drop the packet and return to S_IDLE.
REQ-014 S_WRITE SHALL assert nt_wr_en for exactly one cycle, then go to S_HOLD.
REQ-015 S_HOLD SHALL deassert nt_wr_en and hold nt_index and data for one cycle (the table commits one cycle after wr_en), then go to S_IDLE.
REQ-016 nt_nodeID, nt_hops, nt_qvalue, nt_energy, nt_CHhops SHALL be the latched fields, stable from S_WRITE through S_HOLD.
REQ-017 Latency (accept to write strobe) SHALL be 1 cycle for an empty table, else (k+1)+1 cycles for a match at k, or N+1 cycles for a new entry with N entries; ready SHALL return 2 cycles after the strobe.
REQ-018 HB_reset in any state SHALL, at the next edge:
- clear neighbor_total to 0;
- force S_IDLE and discard any pending packet;
- deassert nt_wr_en.
HB_reset SHALL take priority over a simultaneous handshake or write.
REQ-019 neighbor_total SHALL saturate at MAX_NEIGHBORS and never wrap.
REQ-020 Outside S_SCAN, S_WRITE and S_HOLD, nt_index SHALL be 0.

Reset
REQ-021 nrst low SHALL asynchronously set:
- state = S_IDLE;
- neighbor_total = 0;
- nt_wr_en = 0;
- nt_index = 0;
- all latched fields and data outputs = 0.
REQ-022 After nrst release, pkt_ready SHALL be 1 in the first cycle if HB_reset==0.
REQ-023 Reset mid-scan or mid-write SHALL abandon the operation, and no write strobe SHALL follow.

Structure
REQ-024 A shared package SHALL hold the pkt_type codes (PKT_MEMREQ=3'd2, PKT_DATA=3'd3, PKT_SOS=3'd4), the FSM state enum, and MY_NODE_ID_DEFAULT.
REQ-025 The block SHALL be a single module with no sub-module; the scan counter and the FSM live in it.

Verification
REQ-026 Empty table, MEMREQ srcID=0x0005, chosenCH match -> nt_wr_en 1 cycle after accept with nt_index=0; neighbor_total=1; nt_nodeID=0x0005 held through S_HOLD.
REQ-027 Table holds 0x0005 (slot 0) and 0x0007 (slot 1); DATA from 0x0007 with energy 0x1234 -> scan 2 cycles, write slot 1, neighbor_total stays 2.
REQ-028 Three packets rejected for: srcID=0x000C; chosenCH mismatch; pkt_type=3'd1 -> no nt_wr_en, pkt_ready stays 1, neighbor_total unchanged.
REQ-029 Fill 32 distinct IDs, then new ID 0x0040 -> table_full=1, packet dropped after 32 scan cycles, no write; an existing ID still updates.
REQ-030 HB_reset asserted during S_SCAN with 10 entries -> next cycle S_IDLE, neighbor_total=0, no nt_wr_en; the next packet writes slot 0.
REQ-031 nrst pulsed during S_WRITE -> nt_wr_en drops immediately, all outputs 0, no write strobe before the next accepted packet.
